// File: rtl/mc97_codec_if.sv
// Link, register-bus, PCM and GPIO signals of the MC97 codec front-end.
// master = host/responder side, slave = codec.
interface mc97_codec_if;
  logic        mc97_sync;
  logic        mc97_sdata_out;
  logic        mc97_sdata_in;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_stb;
  logic [15:0] reg_rdata;
  logic [15:0] pcm_rx_data;
  logic        pcm_rx_stb;
  logic [15:0] pcm_tx_data;
  logic        pcm_tx_ack;
  logic [19:0] gpio_out;
  logic [19:0] gpio_in;
  logic        codec_ready;
  logic        frame_err;

  modport master (
    output mc97_sync, mc97_sdata_out, reg_rdata, pcm_tx_data, gpio_in,
    input  mc97_sdata_in, reg_addr, reg_wdata, reg_we, reg_stb, pcm_rx_data, pcm_rx_stb,
           pcm_tx_ack, gpio_out, codec_ready, frame_err
  );

  modport slave (
    input  mc97_sync, mc97_sdata_out, reg_rdata, pcm_tx_data, gpio_in,
    output mc97_sdata_in, reg_addr, reg_wdata, reg_we, reg_stb, pcm_rx_data, pcm_rx_stb,
           pcm_tx_ack, gpio_out, codec_ready, frame_err
  );
endinterface

// File: rtl/mc97_codec.sv
// Codec end of the MC97 link: deframes host SDATA_OUT into register/PCM/GPIO events and
// frames the codec SDATA_IN reply. Single bit-clock domain.
module mc97_codec #(
  parameter int unsigned SLOT_PCM     = 5,
  parameter int unsigned READY_FRAMES = 2
) (
  input logic         clk,
  input logic         rst_n,
  mc97_codec_if.slave bus
);
  localparam int unsigned TagPcm   = 15 - SLOT_PCM;
  localparam int unsigned SlotReq  = 14 - SLOT_PCM;
  localparam int unsigned PcmHi    = 239 - 20 * (SLOT_PCM - 1);
  localparam logic [7:0]  PcmLast  = 8'(35 + 20 * (SLOT_PCM - 1));
  localparam logic [3:0]  ReadyMax = 4'(READY_FRAMES);

  typedef enum logic [0:0] {StIdle = 1'b0, StRun = 1'b1} state_e;

  state_e       state_q;
  logic [7:0]   cnt_q;
  logic         sync_q;
  logic [255:0] tx_q;
  logic         sdata_in_q;
  logic [18:0]  rx_sh_q;
  logic         tag_valid_q, tag_ctl_q, tag_data_q, tag_pcm_q, tag_gpio_q;
  logic         slot1_rd_q;
  logic [5:0]   slot1_addr_q;
  logic         pend_q;
  logic [5:0]   stat_addr_q;
  logic [15:0]  stat_data_q;
  logic [3:0]   ready_cnt_q;
  logic [5:0]   reg_addr_q;
  logic [15:0]  reg_wdata_q;
  logic         reg_we_q, reg_stb_q;
  logic [15:0]  pcm_rx_data_q;
  logic         pcm_rx_stb_q, pcm_tx_ack_q;
  logic [19:0]  gpio_out_q;
  logic         frame_err_q;

  logic         sync_rise;
  logic         codec_ready;
  logic [19:0]  rx_word;
  logic [15:0]  tx_tag;
  logic [19:0]  tx_slot1;
  logic [255:0] tx_frame;

  assign sync_rise   = bus.mc97_sync & ~sync_q;
  assign codec_ready = (ready_cnt_q == ReadyMax);
  // Current slot word including the bit sampled this cycle; low 16 bits form the tag at bit 15.
  assign rx_word     = {rx_sh_q, bus.mc97_sdata_out};

  always_comb begin
    tx_tag         = '0;
    tx_tag[15]     = codec_ready;
    tx_tag[14]     = pend_q;
    tx_tag[13]     = pend_q;
    tx_tag[TagPcm] = codec_ready;
    tx_tag[3]      = codec_ready;
    tx_slot1       = '0;
    if (pend_q) tx_slot1[18:12] = {stat_addr_q, 1'b0};
    tx_slot1[11:2] = '1;
    if (codec_ready) tx_slot1[SlotReq] = 1'b0;
    tx_frame            = '0;
    tx_frame[255:240]   = tx_tag;
    tx_frame[239:220]   = tx_slot1;
    tx_frame[219:200]   = pend_q ? {stat_data_q, 4'h0} : 20'h0;
    tx_frame[PcmHi -: 20] = {bus.pcm_tx_data, 4'h0};
    tx_frame[19:0]      = bus.gpio_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sync_q        <= 1'b0;
      tx_q          <= '0;
      sdata_in_q    <= 1'b0;
      rx_sh_q       <= '0;
      tag_valid_q   <= 1'b0;
      tag_ctl_q     <= 1'b0;
      tag_data_q    <= 1'b0;
      tag_pcm_q     <= 1'b0;
      tag_gpio_q    <= 1'b0;
      slot1_rd_q    <= 1'b0;
      slot1_addr_q  <= '0;
      pend_q        <= 1'b0;
      stat_addr_q   <= '0;
      stat_data_q   <= '0;
      ready_cnt_q   <= '0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      reg_we_q      <= 1'b0;
      reg_stb_q     <= 1'b0;
      pcm_rx_data_q <= '0;
      pcm_rx_stb_q  <= 1'b0;
      pcm_tx_ack_q  <= 1'b0;
      gpio_out_q    <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      sync_q       <= bus.mc97_sync;
      reg_stb_q    <= 1'b0;
      pcm_rx_stb_q <= 1'b0;
      pcm_tx_ack_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (sync_rise) begin
        // A rise mid-frame drops that frame; this cycle is still bit 0 of the new one.
        frame_err_q  <= (state_q == StRun) && (cnt_q != 8'd255);
        state_q      <= StRun;
        cnt_q        <= 8'd1;
        sdata_in_q   <= tx_frame[255];
        tx_q         <= {tx_frame[254:0], 1'b0};
        rx_sh_q      <= rx_word[18:0];
        tag_valid_q  <= 1'b0;
        pcm_tx_ack_q <= codec_ready;
        pend_q       <= 1'b0;
      end else if (state_q == StRun) begin
        sdata_in_q <= tx_q[255];
        tx_q       <= {tx_q[254:0], 1'b0};
        rx_sh_q    <= rx_word[18:0];
        cnt_q      <= cnt_q + 8'd1;
        if (cnt_q == 8'd15) begin
          tag_valid_q <= rx_word[15];
          tag_ctl_q   <= rx_word[14];
          tag_data_q  <= rx_word[13];
          tag_pcm_q   <= rx_word[TagPcm];
          tag_gpio_q  <= rx_word[3];
        end
        if (cnt_q == 8'd35) begin
          slot1_rd_q   <= rx_word[19];
          slot1_addr_q <= rx_word[18:13];
          if (tag_valid_q && tag_ctl_q && rx_word[19]) begin
            reg_stb_q  <= 1'b1;
            reg_we_q   <= 1'b0;
            reg_addr_q <= rx_word[18:13];
          end
        end
        if (cnt_q == 8'd55 && tag_valid_q && tag_ctl_q && tag_data_q && !slot1_rd_q) begin
          reg_stb_q   <= 1'b1;
          reg_we_q    <= 1'b1;
          reg_addr_q  <= slot1_addr_q;
          reg_wdata_q <= rx_word[19:4];
        end
        if (cnt_q == PcmLast && tag_valid_q && tag_pcm_q) begin
          pcm_rx_data_q <= rx_word[19:4];
          pcm_rx_stb_q  <= 1'b1;
        end
        if (cnt_q == 8'd255) begin
          state_q <= StIdle;
          if (ready_cnt_q != ReadyMax) ready_cnt_q <= ready_cnt_q + 4'd1;
          if (tag_valid_q && tag_gpio_q) gpio_out_q <= rx_word;
        end
      end else begin
        sdata_in_q <= 1'b0;
      end
      if (reg_stb_q && !reg_we_q) begin
        pend_q      <= 1'b1;
        stat_addr_q <= reg_addr_q;
        stat_data_q <= bus.reg_rdata;
      end
    end
  end

  assign bus.mc97_sdata_in = sdata_in_q;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.reg_we        = reg_we_q;
  assign bus.reg_stb       = reg_stb_q;
  assign bus.pcm_rx_data   = pcm_rx_data_q;
  assign bus.pcm_rx_stb    = pcm_rx_stb_q;
  assign bus.pcm_tx_ack    = pcm_tx_ack_q;
  assign bus.gpio_out      = gpio_out_q;
  assign bus.codec_ready   = codec_ready;
  assign bus.frame_err     = frame_err_q;
endmodule

// File: tb/tb_mc97_codec.sv
// Directed bench for mc97_codec: host frames are driven bit by bit, the codec reply is
// captured, and register/PCM events are scoreboarded against expected queues.
module tb_mc97_codec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc97_codec_if bus ();

  mc97_codec #(
    .SLOT_PCM    (5),
    .READY_FRAMES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
  } reg_t;

  reg_t         obs_reg[$];
  reg_t         exp_reg[$];
  logic [15:0]  obs_pcm[$];
  logic [15:0]  exp_pcm[$];
  int           ack_cnt = 0;
  int           err_cnt = 0;
  int           errors = 0;
  int           checks = 0;
  logic [255:0] tx_cap;

  always @(negedge clk) begin
    if (bus.reg_stb) obs_reg.push_back({bus.reg_we, bus.reg_addr, bus.reg_wdata});
    if (bus.pcm_rx_stb) obs_pcm.push_back(bus.pcm_rx_data);
    if (bus.pcm_tx_ack) ack_cnt++;
    if (bus.frame_err) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] tx_slot(input int n);
    return tx_cap[239 - 20 * (n - 1) -: 20];
  endfunction

  // Drives one host frame; abort_at < 256 stops before that bit so the next call re-rises SYNC.
  task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                            input logic [19:0] s5, input logic [19:0] s12, input int abort_at);
    logic [255:0] v;
    v            = '0;
    v[255:240]   = tag;
    v[239:220]   = s1;
    v[219:200]   = s2;
    v[159:140]   = s5;
    v[19:0]      = s12;
    tx_cap       = '0;
    for (int k = 0; k < 256; k++) begin
      if (k == abort_at) return;
      @(negedge clk);
      if (k > 0) tx_cap[256 - k] = bus.mc97_sdata_in;
      bus.mc97_sync      = (k < 16);
      bus.mc97_sdata_out = v[255 - k];
    end
    @(negedge clk);
    tx_cap[0]          = bus.mc97_sdata_in;
    bus.mc97_sync      = 1'b0;
    bus.mc97_sdata_out = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    reg_t o, e;
    chk({tag, "_reg_count"}, obs_reg.size(), exp_reg.size());
    while (exp_reg.size() > 0 && obs_reg.size() > 0) begin
      o = obs_reg.pop_front();
      e = exp_reg.pop_front();
      chk({tag, "_reg_we_addr"}, {o.we, o.addr}, {e.we, e.addr});
      if (e.we) chk({tag, "_reg_wdata"}, o.wdata, e.wdata);
    end
    obs_reg.delete();
    exp_reg.delete();
  endtask

  task automatic check_pcm(input string tag);
    chk({tag, "_pcm_count"}, obs_pcm.size(), exp_pcm.size());
    while (exp_pcm.size() > 0 && obs_pcm.size() > 0)
      chk({tag, "_pcm_data"}, obs_pcm.pop_front(), exp_pcm.pop_front());
    obs_pcm.delete();
    exp_pcm.delete();
  endtask

  initial begin
    int ones;
    int a0;
    int e0;
    bus.mc97_sync      = 1'b0;
    bus.mc97_sdata_out = 1'b0;
    bus.reg_rdata      = 16'h0;
    bus.pcm_tx_data    = 16'h0;
    bus.gpio_in        = 20'h0;
    repeat (3) @(negedge clk);
    chk("rst_sdata_in", bus.mc97_sdata_in, 0);
    chk("rst_reg_stb", bus.reg_stb, 0);
    chk("rst_ready", bus.codec_ready, 0);
    chk("rst_gpio_out", bus.gpio_out, 0);
    chk("rst_pcm_rx", bus.pcm_rx_data, 0);
    chk("rst_frame_err", bus.frame_err, 0);
    rst_n = 1'b1;

    ones = 0;
    repeat (1000) begin
      @(negedge clk);
      ones += int'(bus.mc97_sdata_in);
    end
    chk("idle_sdata_in", ones, 0);
    chk("idle_ack", ack_cnt, 0);
    chk("idle_err", err_cnt, 0);
    check_regs("idle");
    check_pcm("idle");

    a0 = ack_cnt;
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    chk("f1_tag", tx_cap[255:240], 16'h0000);
    chk("f1_slot1", tx_slot(1), 20'h00FFC);
    chk("f1_ack", ack_cnt - a0, 0);
    chk("f1_ready", bus.codec_ready, 0);
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    chk("f2_tag", tx_cap[255:240], 16'h0000);
    chk("f2_ready", bus.codec_ready, 1);

    a0 = ack_cnt;
    bus.pcm_tx_data = 16'h5A5A;
    bus.gpio_in     = 20'h12345;
    exp_pcm.push_back(16'hCAFE);
    send_frame(16'h8408, 20'h0, 20'h0, 20'hCAFE0, 20'hB00B5, 256);
    chk("f3_tag", tx_cap[255:240], 16'h8408);
    chk("f3_ack", ack_cnt - a0, 1);
    chk("f3_slot1", tx_slot(1), 20'h00DFC);
    chk("f3_slot5", tx_slot(5), 20'h5A5A0);
    chk("f3_slot12", tx_slot(12), 20'h12345);
    chk("f3_gpio_out", bus.gpio_out, 20'hB00B5);
    check_pcm("f3");
    check_regs("f3");

    exp_reg.push_back({1'b1, 6'h1E, 16'hBABE});
    send_frame(16'hE000, 20'h3C000, 20'hBABE0, 20'h0, 20'h0, 256);
    chk("f4_tag", tx_cap[255:240], 16'h8408);
    check_regs("f4");
    check_pcm("f4");

    bus.reg_rdata = 16'h1234;
    exp_reg.push_back({1'b0, 6'h1E, 16'h0000});
    send_frame(16'hC000, 20'hBC000, 20'h0, 20'h0, 20'h0, 256);
    chk("f5_tag", tx_cap[255:240], 16'h8408);
    chk("f5_slot2", tx_slot(2), 20'h0);
    check_regs("f5");

    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    chk("f6_tag", tx_cap[255:240], 16'hE408);
    chk("f6_slot1", tx_slot(1), 20'h3CDFC);
    chk("f6_slot2", tx_slot(2), 20'h12340);
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    chk("f7_tag", tx_cap[255:240], 16'h8408);
    chk("f7_slot1", tx_slot(1), 20'h00DFC);
    chk("f7_slot2", tx_slot(2), 20'h0);
    check_regs("f7");

    a0 = ack_cnt;
    e0 = err_cnt;
    send_frame(16'h8408, 20'h0, 20'h0, 20'h11110, 20'h77777, 100);
    send_frame(16'h8000, 20'h0, 20'h0, 20'h0, 20'h0, 256);
    chk("f9_frame_err", err_cnt - e0, 1);
    chk("f9_ack", ack_cnt - a0, 2);
    chk("f9_tag", tx_cap[255:240], 16'h8408);
    chk("f9_slot12", tx_slot(12), 20'h12345);
    chk("f9_gpio_out", bus.gpio_out, 20'hB00B5);
    chk("f9_pcm_rx", bus.pcm_rx_data, 16'hCAFE);
    chk("f9_ready", bus.codec_ready, 1);
    check_pcm("f9");
    check_regs("f9");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
